// File: rtl/timer.sv
// Memory-mapped cycle timer: a free-running 32-bit counter and a programmable compare value.
// A match raises a sticky interrupt that stays high until software acknowledges it.
module timer #(
  parameter logic [31:0] CYCLE_ADDR = 32'hffff001c,
  parameter logic [31:0] ACK_ADDR   = 32'hffff006c
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data,
  input  logic [31:0] address,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] cycle,
  output logic        TimerAddress,
  output logic        TimerInterrupt
);

  logic [31:0] cycle_count_r;
  logic [31:0] interrupt_cycle_r;
  logic        interrupt_line_r;

  logic        cycle_sel_s;
  logic        ack_sel_s;
  logic        cycle_wr_s;
  logic        ack_wr_s;
  logic        match_s;

  // Address decode and compare against the pre-edge register values
  always_comb begin
    cycle_sel_s = (address == CYCLE_ADDR);
    ack_sel_s   = (address == ACK_ADDR);
    cycle_wr_s  = MemWrite & cycle_sel_s;
    ack_wr_s    = MemWrite & ack_sel_s;
    match_s     = (cycle_count_r == interrupt_cycle_r);
  end

  // Counter, compare register and sticky interrupt; a match beats a same-cycle acknowledge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_count_r     <= 32'h0000_0000;
      interrupt_cycle_r <= 32'hffff_ffff;
      interrupt_line_r  <= 1'b0;
    end else begin
      cycle_count_r <= cycle_count_r + 32'd1;
      if (cycle_wr_s) begin
        interrupt_cycle_r <= data;
      end
      if (match_s) begin
        interrupt_line_r <= 1'b1;
      end else if (ack_wr_s) begin
        interrupt_line_r <= 1'b0;
      end
    end
  end

  // Read mux: only a load of the counter address returns data, everything else reads zero
  always_comb begin
    if (MemRead && cycle_sel_s) begin
      cycle = cycle_count_r;
    end else begin
      cycle = 32'h0000_0000;
    end
  end

  // Address hit flag and interrupt request
  always_comb begin
    TimerAddress   = cycle_sel_s | ack_sel_s;
    TimerInterrupt = interrupt_line_r;
  end

endmodule
